// File: rtl/store_queue_ring.sv
// Circular store queue indexed by storeSqN: holds stores until commit, drains them in order
// to the cache store port and forwards store bytes to NUM_LD load ports.
module store_queue_ring #(
    parameter int          NUM_ENTRIES = 8,
    parameter int          NUM_EVICT   = 2,
    parameter int          NUM_LD      = 2,
    parameter int          SQN_W       = 7,
    parameter int          STSQN_W     = 6,
    parameter logic [31:0] MMIO_MASK   = 32'hF000_0000,
    parameter logic [31:0] MMIO_MATCH  = 32'hF000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IN_stallSt,
    input  logic                    IN_st_valid,
    input  logic [SQN_W-1:0]        IN_st_sqN,
    input  logic [STSQN_W-1:0]      IN_st_storeSqN,
    input  logic [31:0]             IN_st_addr,
    input  logic [31:0]             IN_st_data,
    input  logic [3:0]              IN_st_wmask,
    input  logic                    IN_st_exc,
    input  logic [NUM_LD-1:0]       IN_ld_valid,
    input  logic [NUM_LD*SQN_W-1:0] IN_ld_sqN,
    input  logic [NUM_LD*32-1:0]    IN_ld_addr,
    input  logic [NUM_LD*2-1:0]     IN_ld_size,
    input  logic [NUM_LD-1:0]       IN_stallLd,
    input  logic [SQN_W-1:0]        IN_curSqN,
    input  logic                    IN_br_taken,
    input  logic                    IN_br_flush,
    input  logic [SQN_W-1:0]        IN_br_sqN,
    output logic                    OUT_st_valid,
    output logic [31:0]             OUT_st_addr,
    output logic [31:0]             OUT_st_data,
    output logic [3:0]              OUT_st_wmask,
    output logic [NUM_LD*32-1:0]    OUT_ldData,
    output logic [NUM_LD*4-1:0]     OUT_ldMask,
    output logic                    OUT_empty,
    output logic                    OUT_done,
    output logic                    OUT_flush,
    output logic [STSQN_W-1:0]      OUT_maxStoreSqN
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    function automatic logic is_mmio(input logic [31:0] a);
        return (a & MMIO_MASK) == MMIO_MATCH;
    endfunction

    // $signed(a - b) > 0, wrap-safe
    function automatic logic sqn_after(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

    // $signed(a - b) < 0, wrap-safe
    function automatic logic sqn_before(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return diff[SQN_W-1];
    endfunction

    logic [NUM_ENTRIES-1:0] valid_q, valid_d, ready_q, ready_d;
    logic [SQN_W-1:0]       sqn_q   [NUM_ENTRIES];
    logic [SQN_W-1:0]       sqn_d   [NUM_ENTRIES];
    logic [31:0]            addr_q  [NUM_ENTRIES];
    logic [31:0]            addr_d  [NUM_ENTRIES];
    logic [31:0]            data_q  [NUM_ENTRIES];
    logic [31:0]            data_d  [NUM_ENTRIES];
    logic [3:0]             wmask_q [NUM_ENTRIES];
    logic [3:0]             wmask_d [NUM_ENTRIES];

    logic [NUM_EVICT-1:0]   ev_valid_q, ev_valid_d;
    logic [31:0]            ev_addr_q  [NUM_EVICT];
    logic [31:0]            ev_addr_d  [NUM_EVICT];
    logic [31:0]            ev_data_q  [NUM_EVICT];
    logic [31:0]            ev_data_d  [NUM_EVICT];
    logic [3:0]             ev_wmask_q [NUM_EVICT];
    logic [3:0]             ev_wmask_d [NUM_EVICT];

    logic [STSQN_W-1:0]     head_q, head_d, max_sqn_q, max_sqn_d;
    logic                   mmio_hold_q, mmio_hold_d;
    logic                   st_valid_q, st_valid_d;
    logic [31:0]            st_addr_q, st_addr_d, st_data_q, st_data_d;
    logic [3:0]             st_wmask_q, st_wmask_d;
    logic                   empty_q, empty_d, flush_q, flush_d;

    logic [IDX_W-1:0]       head_idx, enq_idx;
    logic                   head_valid, head_ready, head_mmio, deq, enq;
    logic [STSQN_W-1:0]     enq_dist;

    assign head_idx   = head_q[IDX_W-1:0];
    assign enq_idx    = IN_st_storeSqN[IDX_W-1:0];
    assign head_valid = valid_q[head_idx];
    assign head_ready = ready_q[head_idx];
    assign head_mmio  = is_mmio(addr_q[head_idx]);
    assign deq = head_valid && head_ready && !IN_stallSt && !IN_br_taken &&
                 (!mmio_hold_q || head_mmio);
    assign enq = IN_st_valid && !IN_st_exc && (!IN_br_taken || !sqn_after(IN_st_sqN, IN_br_sqN));
    assign enq_dist = IN_st_storeSqN - head_q;

    assert property (@(posedge clk) disable iff (rst) enq |-> (enq_dist < STSQN_W'(NUM_ENTRIES)));

    // Entry state: commit, branch kill, dequeue, then enqueue (enqueue wins on the same slot)
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        sqn_d   = sqn_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wmask_d = wmask_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sqn_after(IN_curSqN, sqn_q[i])) ready_d[i] = 1'b1;
            if (IN_br_taken && !ready_q[i] && sqn_after(sqn_q[i], IN_br_sqN)) valid_d[i] = 1'b0;
        end
        if (deq) valid_d[head_idx] = 1'b0;
        if (enq) begin
            valid_d[enq_idx] = 1'b1;
            ready_d[enq_idx] = 1'b0;
            sqn_d[enq_idx]   = IN_st_sqN;
            addr_d[enq_idx]  = IN_st_addr;
            data_d[enq_idx]  = IN_st_data;
            wmask_d[enq_idx] = IN_st_wmask;
        end
    end

    always_comb begin
        head_d      = head_q + STSQN_W'(deq);
        st_valid_d  = st_valid_q;
        st_addr_d   = st_addr_q;
        st_data_d   = st_data_q;
        st_wmask_d  = st_wmask_q;
        mmio_hold_d = mmio_hold_q;
        ev_valid_d  = ev_valid_q;
        ev_addr_d   = ev_addr_q;
        ev_data_d   = ev_data_q;
        ev_wmask_d  = ev_wmask_q;
        if (deq) begin
            st_valid_d  = 1'b1;
            st_addr_d   = addr_q[head_idx];
            st_data_d   = data_q[head_idx];
            st_wmask_d  = wmask_q[head_idx];
            mmio_hold_d = head_mmio;
            for (int e = 0; e < NUM_EVICT - 1; e++) begin
                ev_valid_d[e] = ev_valid_q[e+1];
                ev_addr_d[e]  = ev_addr_q[e+1];
                ev_data_d[e]  = ev_data_q[e+1];
                ev_wmask_d[e] = ev_wmask_q[e+1];
            end
            ev_valid_d[NUM_EVICT-1] = 1'b1;
            ev_addr_d[NUM_EVICT-1]  = addr_q[head_idx];
            ev_data_d[NUM_EVICT-1]  = data_q[head_idx];
            ev_wmask_d[NUM_EVICT-1] = wmask_q[head_idx];
        end else if (!IN_stallSt) begin
            // An idle port cycle releases the MMIO hold, giving one bubble after an MMIO store
            st_valid_d  = 1'b0;
            mmio_hold_d = 1'b0;
        end
        if (flush_q) ev_valid_d = '0;
        flush_d   = IN_br_flush ? 1'b1 : (empty_q ? 1'b0 : flush_q);
        empty_d   = (valid_q == '0) && !enq;
        max_sqn_d = head_d + STSQN_W'(NUM_ENTRIES - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            ready_q     <= '0;
            ev_valid_q  <= '0;
            head_q      <= '0;
            max_sqn_q   <= STSQN_W'(NUM_ENTRIES - 1);
            mmio_hold_q <= 1'b0;
            st_valid_q  <= 1'b0;
            st_addr_q   <= '0;
            st_data_q   <= '0;
            st_wmask_q  <= '0;
            empty_q     <= 1'b1;
            flush_q     <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                sqn_q[i]   <= '0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                wmask_q[i] <= '0;
            end
            for (int e = 0; e < NUM_EVICT; e++) begin
                ev_addr_q[e]  <= '0;
                ev_data_q[e]  <= '0;
                ev_wmask_q[e] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            sqn_q       <= sqn_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wmask_q     <= wmask_d;
            ev_valid_q  <= ev_valid_d;
            ev_addr_q   <= ev_addr_d;
            ev_data_q   <= ev_data_d;
            ev_wmask_q  <= ev_wmask_d;
            head_q      <= head_d;
            max_sqn_q   <= max_sqn_d;
            mmio_hold_q <= mmio_hold_d;
            st_valid_q  <= st_valid_d;
            st_addr_q   <= st_addr_d;
            st_data_q   <= st_data_d;
            st_wmask_q  <= st_wmask_d;
            empty_q     <= empty_d;
            flush_q     <= flush_d;
        end
    end

    assign OUT_st_valid    = st_valid_q;
    assign OUT_st_addr     = st_addr_q;
    assign OUT_st_data     = st_data_q;
    assign OUT_st_wmask    = st_wmask_q;
    assign OUT_empty       = empty_q;
    assign OUT_flush       = flush_q;
    assign OUT_maxStoreSqN = max_sqn_q;
    assign OUT_done = (!head_valid || (!head_ready && !sqn_after(IN_curSqN, sqn_q[head_idx]))) &&
                      !IN_stallSt;

    for (genvar gi = 0; gi < NUM_LD; gi++) begin : g_ld
        logic [31:0]      la;
        logic [SQN_W-1:0] lsqn;
        logic [1:0]       lsize;
        logic [31:0]      fwd_data, ld_data_q, ld_data_d;
        logic [3:0]       fwd_mask, ld_mask_q, ld_mask_d;
        logic [IDX_W-1:0] idx;

        assign la    = IN_ld_addr[gi*32 +: 32];
        assign lsqn  = IN_ld_sqN[gi*SQN_W +: SQN_W];
        assign lsize = IN_ld_size[gi*2 +: 2];

        // Oldest first so that younger stores override per byte
        always_comb begin
            fwd_data = '0;
            idx      = '0;
            case (lsize)
                2'd0:    fwd_mask = ~(4'b0001 << la[1:0]);
                2'd1:    fwd_mask = la[1] ? ~4'b1100 : ~4'b0011;
                default: fwd_mask = 4'b0000;
            endcase
            for (int e = 0; e < NUM_EVICT; e++) begin
                if (ev_valid_q[e] && ev_addr_q[e][31:2] == la[31:2] && !is_mmio(ev_addr_q[e])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ev_wmask_q[e][b]) begin
                            fwd_data[b*8 +: 8] = ev_data_q[e][b*8 +: 8];
                            fwd_mask[b] = 1'b1;
                        end
                    end
                end
            end
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                idx = head_idx + IDX_W'(k);
                if (valid_q[idx] && addr_q[idx][31:2] == la[31:2] && !is_mmio(addr_q[idx]) &&
                    (sqn_before(sqn_q[idx], lsqn) || ready_q[idx])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wmask_q[idx][b]) begin
                            fwd_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
                            fwd_mask[b] = 1'b1;
                        end
                    end
                end
            end
        end

        always_comb begin
            ld_data_d = '0;
            ld_mask_d = '0;
            if (IN_stallLd[gi]) begin
                ld_data_d = ld_data_q;
                ld_mask_d = ld_mask_q;
            end else if (IN_ld_valid[gi]) begin
                ld_data_d = fwd_data;
                ld_mask_d = fwd_mask;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ld_data_q <= '0;
                ld_mask_q <= '0;
            end else begin
                ld_data_q <= ld_data_d;
                ld_mask_q <= ld_mask_d;
            end
        end

        assign OUT_ldData[gi*32 +: 32] = ld_data_q;
        assign OUT_ldMask[gi*4 +: 4]   = ld_mask_q;
    end
endmodule
